alu_74382_wide_seq: RTL
=======================

# alu_74382_wide_seq

Multi-cycle sequencer that runs wide (SLICES × OPERAND_W bit) operations through a single 74382-style ALU slice, one slice per clock, least significant first, chaining carry between slices. Sits between a requester (valid/ready command port) and the combinational `alu_74382`. Gives the design a cheap wide ALU without cascading several chips.

## Interface
Parameters:
- OPERAND_W, 4, width of one ALU slice
- SLICES, 4, number of slices per wide operation (≥2); wide width W = OPERAND_W*SLICES

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid && req_ready
- req_sel  in  3  74382 function select, alu_sel_t encoding
- req_carry_in  in  1  carry into slice 0
- req_a  in  W  operand A
- req_b  in  W  operand B
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed when rsp_valid && rsp_ready
- rsp_result  out  W  wide result
- rsp_carry_out  out  1  carry_out of most significant slice
- rsp_overflow  out  1  overflow of most significant slice
- rsp_zero  out  1  only with ALU_SEQ_ZERO_FLAG_EN, see Configuration

## Operation
- FSM states: IDLE, RUN, DONE (alu_seq_state_t).
- IDLE: req_ready=1. On accept, latch sel, A, B, carry_in into the carry register; idx←0; go to RUN.
- RUN: ALU driven with latched sel, slice idx of A and B, carry register. Each edge: store ALU result into rsp_result slice idx; carry register←ALU carry_out; idx++. On the edge where idx==SLICES-1, also latch rsp_carry_out and rsp_overflow from the ALU; go to DONE.
- DONE: rsp_valid=1, outputs stable. On rsp_ready, go to IDLE. No new command accepted in RUN or DONE (req_ready=0).
- Function semantics come from the ALU: CLEAR→0, PRESET→all ones, logic ops per slice, arithmetic chained through carry. B-minus-A and A-minus-B need req_carry_in=1 for true two's complement; the sequencer does not force it.
- Carry/overflow for logic, CLEAR and PRESET ops: whatever the MS slice ALU reports, forwarded unchanged.
- req_* inputs are ignored outside IDLE. Changing them after accept does not affect the running operation.
- Reset (asynchronous, any state, including mid-RUN): state←IDLE, idx←0, rsp_valid←0, rsp_result←0, rsp_carry_out←0, rsp_overflow←0, carry register←0. The in-flight operation is discarded. req_ready=1 immediately after reset.

## Timing
- Accept edge E0. RUN occupies edges E1..E_SLICES. rsp_valid is high after E_SLICES, so result latency is SLICES cycles from accept.
- The minimum op period is SLICES+2 cycles (one IDLE cycle, SLICES RUN cycles, at least one DONE cycle).
- req_ready and rsp_valid are decoded from registered state only. No combinational path from req_valid or rsp_ready to either.
- The ALU path (slice mux → ALU → result/carry registers) is the single-cycle critical path.

## Configuration
- ALU_SEQ_ZERO_FLAG_EN defined: rsp_zero port exists. Each RUN cycle accumulates zero = zero && (slice result==0), with zero initialised to 1 on accept. rsp_zero is valid with rsp_valid and resets to 0.
- ALU_SEQ_ZERO_FLAG_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- alu_74382_pkg gains alu_seq_state_t (IDLE/RUN/DONE). alu_74382_pkg already holds alu_sel_t and the function encodings; both modules import it.
- One sub-module: alu_74382 (OPERAND_W=RESULT_W=OPERAND_W), instantiated once inside the sequencer.
- Slice index counter width is $clog2(SLICES).

## Test plan
(SLICES=4, OPERAND_W=4, W=16)
- ADD 0x0FFF+0x0001, cin=0 → result 0x1000, carry_out 0, overflow 0. rsp_valid rises 4 cycles after accept.
- ADD 0x7FFF+0x0001, cin=0 → result 0x8000, overflow 1, carry_out 0. ADD 0xFFFF+0x0001 → 0x0000, carry_out 1.
- A-minus-B 0x1234−0x0235, cin=1 → result 0x0FFF, carry_out 1. XOR 0xA5A5^0xFFFF → 0x5A5A.
- Backpressure: rsp_ready held low 5 cycles in DONE → outputs stable and req_ready=0. A concurrent req_valid is not accepted. After rsp_ready, the next command is accepted in IDLE.
- Reset asserted after 2 RUN cycles → rsp_valid 0, outputs 0, req_ready 1. The next ADD 0x0001+0x0001 gives 0x0002.
- With ALU_SEQ_ZERO_FLAG_EN: CLEAR → 0x0000, rsp_zero 1. PRESET → 0xFFFF, rsp_zero 0. AND 0xF000&0x0F00 → 0x0000, rsp_zero 1.

Source files
------------

// File: rtl/alu_74382_pkg.sv
// Shared types for the 74382-style ALU slice and its wide sequencer.
// Holds the function-select encoding and the sequencer FSM states.
package alu_74382_pkg;

    typedef enum logic [2:0] {
        SEL_CLEAR     = 3'b000,
        SEL_B_MINUS_A = 3'b001,
        SEL_A_MINUS_B = 3'b010,
        SEL_A_PLUS_B  = 3'b011,
        SEL_XOR       = 3'b100,
        SEL_OR        = 3'b101,
        SEL_AND       = 3'b110,
        SEL_PRESET    = 3'b111
    } alu_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } alu_seq_state_t;

endpackage

// File: rtl/alu_74382.sv
// Combinational 74382-style ALU slice: CLEAR/PRESET, logic ops and
// carry-chained add/subtract. Logic ops report carry_out=0, overflow=0.
module alu_74382
    import alu_74382_pkg::*;
#(
    parameter int OPERAND_W = 4,
    parameter int RESULT_W  = OPERAND_W
) (
    input  alu_sel_t               sel,
    input  logic                   carry_in,
    input  logic [OPERAND_W-1:0]   a,
    input  logic [OPERAND_W-1:0]   b,
    output logic [RESULT_W-1:0]    result,
    output logic                   carry_out,
    output logic                   overflow
);

    logic [OPERAND_W-1:0] x;
    logic [OPERAND_W-1:0] y;
    logic [OPERAND_W-1:0] f;
    logic [OPERAND_W:0]   sum;
    logic                 arith;

    always_comb begin
        x         = a;
        y         = b;
        f         = '0;
        arith     = 1'b0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        unique case (sel)
            SEL_CLEAR:     f = '0;
            SEL_B_MINUS_A: begin x = b; y = ~a; arith = 1'b1; end
            SEL_A_MINUS_B: begin x = a; y = ~b; arith = 1'b1; end
            SEL_A_PLUS_B:  arith = 1'b1;
            SEL_XOR:       f = a ^ b;
            SEL_OR:        f = a | b;
            SEL_AND:       f = a & b;
            SEL_PRESET:    f = '1;
            default:       f = '0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{OPERAND_W{1'b0}}, carry_in};
        if (arith) begin
            f         = sum[OPERAND_W-1:0];
            carry_out = sum[OPERAND_W];
            // Signed overflow: like-signed addends, differently-signed sum
            overflow  = (x[OPERAND_W-1] == y[OPERAND_W-1]) &&
                        (sum[OPERAND_W-1] != x[OPERAND_W-1]);
        end
    end

    assign result = RESULT_W'(f);

endmodule

// File: rtl/alu_74382_wide_seq.sv
// Runs SLICES x OPERAND_W wide ops through one alu_74382, one slice per clock.
// Optional rsp_zero flag is built when ALU_SEQ_ZERO_FLAG_EN is defined.
module alu_74382_wide_seq
    import alu_74382_pkg::*;
#(
    parameter int OPERAND_W = 4,
    parameter int SLICES    = 4,
    localparam int W        = OPERAND_W * SLICES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_sel,
    input  logic         req_carry_in,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_carry_out,
    output logic         rsp_overflow
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic         rsp_zero
`endif
);

    localparam int IDX_W = $clog2(SLICES);

    alu_seq_state_t       state;
    alu_seq_state_t       state_n;
    logic [IDX_W-1:0]     idx;
    alu_sel_t             sel_q;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic                 carry_q;
    logic [OPERAND_W-1:0] a_slice;
    logic [OPERAND_W-1:0] b_slice;
    logic [OPERAND_W-1:0] f;
    logic                 alu_co;
    logic                 alu_ov;
    logic                 last;
    logic                 accept;

    assign a_slice = a_q[int'(idx)*OPERAND_W +: OPERAND_W];
    assign b_slice = b_q[int'(idx)*OPERAND_W +: OPERAND_W];
    assign last    = (idx == IDX_W'(SLICES - 1));
    assign accept  = (state == IDLE) && req_valid;

    alu_74382 #(
        .OPERAND_W (OPERAND_W),
        .RESULT_W  (OPERAND_W)
    ) u_alu (
        .sel       (sel_q),
        .carry_in  (carry_q),
        .a         (a_slice),
        .b         (b_slice),
        .result    (f),
        .carry_out (alu_co),
        .overflow  (alu_ov)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Handshake outputs depend on registered state only
    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = RUN;
            end
            RUN: begin
                if (last) state_n = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            sel_q         <= SEL_CLEAR;
            a_q           <= '0;
            b_q           <= '0;
            carry_q       <= 1'b0;
            rsp_result    <= '0;
            rsp_carry_out <= 1'b0;
            rsp_overflow  <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            sel_q   <= alu_sel_t'(req_sel);
            a_q     <= req_a;
            b_q     <= req_b;
            carry_q <= req_carry_in;
        end else if (state == RUN) begin
            rsp_result[int'(idx)*OPERAND_W +: OPERAND_W] <= f;
            carry_q <= alu_co;
            if (last) begin
                idx           <= '0;
                rsp_carry_out <= alu_co;
                rsp_overflow  <= alu_ov;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                rsp_zero <= 1'b0;
        else if (accept)        rsp_zero <= 1'b1;
        else if (state == RUN)  rsp_zero <= rsp_zero && (f == '0);
    end
`endif

endmodule
